// File: rtl/nonce_gen_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_gen_multi_if
//  Description : Handshake/bus bundle for the multi-lane nonce generator.
//                The master side (consumer/controller) drives load, seed_in,
//                stride_in, mode, next and fin. The slave side (generator)
//                returns nonce, nonce_valid, exhausted and iter.
//  Ports       : load, seed_in[WIDTH], stride_in[WIDTH], mode, next, fin
//                nonce[LANES*WIDTH], nonce_valid, exhausted, iter[32]
//  Revision    : 1.0 - initial release
// ============================================================================
interface nonce_gen_multi_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic                     load;
    logic [WIDTH-1:0]         seed_in;
    logic [WIDTH-1:0]         stride_in;
    logic                     mode;
    logic                     next;
    logic                     fin;
    logic [LANES*WIDTH-1:0]   nonce;
    logic                     nonce_valid;
    logic                     exhausted;
    logic [31:0]              iter;

    modport master (
        output load, seed_in, stride_in, mode, next, fin,
        input  nonce, nonce_valid, exhausted, iter
    );

    modport slave (
        input  load, seed_in, stride_in, mode, next, fin,
        output nonce, nonce_valid, exhausted, iter
    );
endinterface
`default_nettype wire

// File: rtl/nonce_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_gen_multi
//  Description : Presents LANES nonces in parallel. Mode 0 spaces lanes by a
//                stride (lane i = base + i*stride), mode 1 makes them
//                contiguous (lane i = base + i). Each accepted set advances
//                the base by one full set. fin freezes the current set
//                (sticky HOLD); MAX_ITER accepted advances end the search
//                (DONE). load restarts from any state.
//  Ports       : clk      - clock, rising edge
//                reset_L  - asynchronous active-low reset
//                bus      - nonce_gen_multi_if slave modport
//                           (load/seed_in/stride_in/mode/next/fin in,
//                            nonce/nonce_valid/exhausted/iter out)
//  Revision    : 1.0 - initial release
// ============================================================================
module nonce_gen_multi #(
    parameter int          WIDTH    = 32,
    parameter int          LANES    = 4,
    parameter logic [31:0] SEED     = 32'h80a9d9e7,
    parameter logic [31:0] STRIDE   = 32'h234b724a,
    parameter logic [31:0] MAX_ITER = 32'hFFFFFFFF
) (
    input  wire logic          clk,
    input  wire logic          reset_L,
    nonce_gen_multi_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [WIDTH-1:0] c_SEED    = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] c_STRIDE  = WIDTH'(STRIDE);
    // LANES reduced modulo 2^WIDTH gives the same wrapped product.
    localparam logic [WIDTH-1:0] c_LANES_W = WIDTH'(LANES);

    // Lane set for a given base/stride/mode; all sums wrap modulo 2^WIDTH.
    function automatic logic [LANES*WIDTH-1:0] f_lanes(
        input logic [WIDTH-1:0] base,
        input logic [WIDTH-1:0] stride,
        input logic             contiguous
    );
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            if (contiguous)
                v[i*WIDTH +: WIDTH] = base + WIDTH'(i);
            else
                v[i*WIDTH +: WIDTH] = base + WIDTH'(i) * stride;
        end
        return v;
    endfunction

    logic [1:0]             r_state;
    logic [WIDTH-1:0]       r_base;
    logic [WIDTH-1:0]       r_stride;
    logic                   r_mode;
    logic [31:0]            r_iter;
    logic [LANES*WIDTH-1:0] r_lanes;
    logic                   r_nonce_valid;
    logic                   r_exhausted;

    logic [WIDTH-1:0]       w_step;
    logic [WIDTH-1:0]       w_next_base;
    logic [LANES*WIDTH-1:0] w_adv_lanes;
    logic [LANES*WIDTH-1:0] w_load_lanes;
    logic [31:0]            w_iter_inc;
    logic                   w_accept;

    always_comb begin
        w_step       = r_mode ? c_LANES_W : c_LANES_W * r_stride;
        w_next_base  = r_base + w_step;
        w_adv_lanes  = f_lanes(w_next_base, r_stride, r_mode);
        w_load_lanes = f_lanes(bus.seed_in, bus.stride_in, bus.mode);
        w_iter_inc   = r_iter + 32'd1;
        // load and fin are handled ahead of this in the priority chain.
        w_accept     = (r_state == c_ST_RUN) && r_nonce_valid && bus.next;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= c_ST_IDLE;
            r_base        <= c_SEED;
            r_stride      <= c_STRIDE;
            r_mode        <= 1'b0;
            r_iter        <= 32'd0;
            r_lanes       <= f_lanes(c_SEED, c_STRIDE, 1'b0);
            r_nonce_valid <= 1'b0;
            r_exhausted   <= 1'b0;
        end else if (bus.load) begin
            r_state       <= c_ST_RUN;
            r_base        <= bus.seed_in;
            r_stride      <= bus.stride_in;
            r_mode        <= bus.mode;
            r_iter        <= 32'd0;
            r_lanes       <= w_load_lanes;
            r_nonce_valid <= 1'b1;
            r_exhausted   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (bus.fin) begin
                        // Freeze the found set; base, lanes and iter untouched.
                        r_state       <= c_ST_HOLD;
                        r_nonce_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_iter <= w_iter_inc;
                        if (w_iter_inc == MAX_ITER) begin
                            // Last permitted advance: lanes keep the final set.
                            r_state       <= c_ST_DONE;
                            r_nonce_valid <= 1'b0;
                            r_exhausted   <= 1'b1;
                        end else begin
                            r_base  <= w_next_base;
                            r_lanes <= w_adv_lanes;
                        end
                    end
                end
                // IDLE, HOLD and DONE only leave on load or reset.
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.nonce       = r_lanes;
    assign bus.nonce_valid = r_nonce_valid;
    assign bus.exhausted   = r_exhausted;
    assign bus.iter        = r_iter;

endmodule
`default_nettype wire

// File: doc/nonce_gen_multi.md
NONCE_GEN_MULTI -- requirements
Module: nonce_gen_multi

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WIDTH, 32, nonce width in bits.
- LANES, 4, number of nonces presented in parallel.
- SEED, 32'h80a9d9e7, reset base value, truncated/zero-extended to WIDTH.
- STRIDE, 32'h234b724a, reset stride, truncated/zero-extended to WIDTH.
- MAX_ITER, 32'hFFFFFFFF, number of accepted advances before exhaustion.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset_L, in, 1, asynchronous, active-low reset.
- load, in, 1, start a new search from seed_in/stride_in/mode.
- seed_in, in, WIDTH, base value captured on load.
- stride_in, in, WIDTH, stride captured on load.
- mode, in, 1, captured on load: 0 = strided lanes, 1 = contiguous lanes.
- next, in, 1, consumer accepts the current nonce set.
- fin, in, 1, solution found: freeze the current set.
- nonce, out, LANES*WIDTH, lane i at bits [i*WIDTH +: WIDTH].
- nonce_valid, out, 1, nonce set is offered.
- exhausted, out, 1, MAX_ITER advances completed.
- iter, out, 32, accepted advances since the last load.

Function
REQ-003 State machine SHALL have four states: IDLE, RUN, HOLD and DONE.
REQ-004 Registered values SHALL be base, stride, mode_r, iter and the lane registers; all outputs SHALL be driven directly from registers.
REQ-005 Mode 0 lane value SHALL be lane[i] = base + i*stride, with i*stride computed as an integer and applied modulo 2^WIDTH.
REQ-006 Mode 0 advance SHALL be base <= base + LANES*stride, computed with the same product rule.
REQ-007 Mode 1 lane value SHALL be lane[i] = base + i; stride is ignored.
REQ-008 Mode 1 advance SHALL be base <= base + LANES.
REQ-009 All nonce arithmetic SHALL wrap modulo 2^WIDTH, with no flag raised on wrap.
REQ-010 A load from any state SHALL, at that edge, capture seed_in, stride_in and mode; set iter to 0; compute the lanes from the new base; and enter RUN.
REQ-011 The new lane values after a load SHALL be visible in the cycle after the load edge, with nonce_valid=1.
REQ-012 nonce_valid SHALL be 1 only in RUN.
REQ-013 In RUN, a set is accepted when nonce_valid=1 and next=1 and fin=0 and load=0.
REQ-014 On acceptance, iter SHALL increment by 1 and the lanes SHALL advance; the new set is visible in the next cycle (one-cycle latency). Back-to-back next SHALL advance every cycle.
REQ-015 In RUN, fin=1 SHALL enter HOLD with lanes, base and iter frozen; fin takes priority over a simultaneous next.
REQ-016 HOLD SHALL be sticky: deasserting fin does not leave HOLD; only load or reset does. The lanes hold the found set for readout.
REQ-017 If an acceptance makes iter equal MAX_ITER, the block SHALL enter DONE at that edge without advancing the lanes, and exhausted SHALL be 1.
REQ-018 In DONE, next and fin SHALL be ignored; only load or reset exits DONE.
REQ-019 In IDLE, next and fin SHALL be ignored.
REQ-020 Priority SHALL be reset_L > load > fin > next.
REQ-021 exhausted SHALL be 1 only in DONE.

Reset
REQ-022 While reset_L=0 (asynchronous), the block SHALL hold:
- state = IDLE;
- base = SEED; stride = STRIDE; mode_r = 0; iter = 0;
- lanes = SEED + i*STRIDE;
- nonce_valid = 0; exhausted = 0.
REQ-023 Reset deasserted mid-search SHALL discard all search state; a load is needed to resume.

Verification
REQ-024 Bench SHALL cover the following scenarios (defaults unless stated):
- Reset: reset_L=0 -> lanes 80A9D9E7, A3F54C31, C740BE7B, EA8C30C5; nonce_valid=0; iter=0.
- Strided: load seed=0, stride=1, mode=0 -> lanes 0,1,2,3; one next -> lanes 4,5,6,7, iter=1.
- Wrap: load seed=FFFFFFFE, stride=1, mode=0 -> lanes FFFFFFFE,FFFFFFFF,0,1; next -> 2,3,4,5.
- Contiguous: load seed=100, stride=7, mode=1 -> lanes 100..103; two back-to-back next -> 108..10B, iter=2.
- Fin collision: fin=1 with next=1 in RUN -> no advance, HOLD, nonce_valid=0, lanes frozen; fin released -> still HOLD; load -> RUN.
- Exhaustion (MAX_ITER=3): three accepted next -> exhausted=1, nonce_valid=0, iter=3, lanes unchanged; further next ignored; load clears both.
